// File: rtl/scan_chain_ctrl_if.sv
// Controller-side scan bus: sequencer handshake plus the se/si/so chain pins.
// Optional compare ports appear when SCAN_CMP_EN is defined.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 16
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pat_in;
  logic                 busy;
  logic                 done;
  logic [CHAIN_LEN-1:0] resp_out;
  logic                 se;
  logic                 si;
  logic                 so;
`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_in;
  logic [CHAIN_LEN-1:0] mask_in;
  logic                 fail;

  modport master (
    input  start, pat_in, so, exp_in, mask_in,
    output busy, done, resp_out, se, si, fail
  );
  modport slave (
    output start, pat_in, so, exp_in, mask_in,
    input  busy, done, resp_out, se, si, fail
  );
`else
  modport master (
    input  start, pat_in, so,
    output busy, done, resp_out, se, si
  );
  modport slave (
    output start, pat_in, so,
    input  busy, done, resp_out, se, si
  );
`endif
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain driver: serialise pattern, pulse capture, deserialise response.
// Define SCAN_CMP_EN to add masked expected-value compare with a fail flag.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN  = 16,
  parameter int CAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr_,
  scan_chain_ctrl_if.master bus
);

  localparam int CNT_MAX = (CHAIN_LEN > CAP_CYCLES) ? CHAIN_LEN : CAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CAP = CNT_W'(CAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] pat_sh;
  logic [CHAIN_LEN-2:0] rsp_sh;
  logic [CHAIN_LEN-1:0] resp_q;
  logic                 se_q;
  logic                 si_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CHAIN_LEN-1:0] rsp_nxt;

  // so is taken before the chain moves, so the oldest bit ends up in the MSB
  assign rsp_nxt = {rsp_sh, bus.so};

`ifdef SCAN_CMP_EN
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic                 fail_q;

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      exp_q  <= '0;
      mask_q <= '0;
      fail_q <= 1'b0;
    end else begin
      if (bus.start && (state == IDLE || state == DONE)) begin
        exp_q  <= bus.exp_in;
        mask_q <= bus.mask_in;
      end
      if (state == SHIFT_OUT && cnt == LAST_BIT)
        fail_q <= |((rsp_nxt ^ exp_q) & mask_q);
    end
  end

  assign bus.fail = fail_q;
`endif

  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state  <= IDLE;
      cnt    <= '0;
      pat_sh <= '0;
      rsp_sh <= '0;
      resp_q <= '0;
      se_q   <= 1'b0;
      si_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state  <= SHIFT_IN;
            cnt    <= '0;
            si_q   <= bus.pat_in[CHAIN_LEN-1];
            pat_sh <= {bus.pat_in[CHAIN_LEN-2:0], 1'b0};
            se_q   <= 1'b1;
            busy_q <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT_IN: begin
          if (cnt == LAST_BIT) begin
            state <= CAPTURE;
            cnt   <= '0;
            se_q  <= 1'b0;
            si_q  <= 1'b0;
          end else begin
            cnt    <= cnt + 1'b1;
            si_q   <= pat_sh[CHAIN_LEN-1];
            pat_sh <= {pat_sh[CHAIN_LEN-2:0], 1'b0};
          end
        end
        CAPTURE: begin
          if (cnt == LAST_CAP) begin
            state <= SHIFT_OUT;
            cnt   <= '0;
            se_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT_OUT: begin
          rsp_sh <= rsp_nxt[CHAIN_LEN-2:0];
          if (cnt == LAST_BIT) begin
            state  <= DONE;
            cnt    <= '0;
            se_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            resp_q <= rsp_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.se       = se_q;
  assign bus.si       = si_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.resp_out = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl driving behavioural 16-cell chains whose
// capture inverts every cell; covers CAP_CYCLES of 1 and 3.
module tb_scan_chain_ctrl;
  localparam int CL = 16;

  logic clk = 1'b0;
  logic clr_;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl_if #(.CHAIN_LEN(CL)) ba ();
  scan_chain_ctrl_if #(.CHAIN_LEN(CL)) bb ();

  scan_chain_ctrl #(.CHAIN_LEN(CL), .CAP_CYCLES(1)) dut_a (.clk(clk), .clr_(clr_), .bus(ba));
  scan_chain_ctrl #(.CHAIN_LEN(CL), .CAP_CYCLES(3)) dut_b (.clk(clk), .clr_(clr_), .bus(bb));

  // Chain models: shift toward cell CL-1 when se=1, capture Q <= ~Q when se=0
  logic [CL-1:0] qa = '0;
  logic [CL-1:0] qb = '0;
  always @(posedge clk) qa <= ba.se ? {qa[CL-2:0], ba.si} : ~qa;
  always @(posedge clk) qb <= bb.se ? {qb[CL-2:0], bb.si} : ~qb;
  assign ba.so = qa[CL-1];
  assign bb.so = qb[CL-1];

  task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [CL-1:0] p;
    int            low;

    clr_        = 1'b0;
    ba.start    = 1'b0;
    ba.pat_in   = '0;
    bb.start    = 1'b0;
    bb.pat_in   = '0;
`ifdef SCAN_CMP_EN
    ba.exp_in   = '0;
    ba.mask_in  = '0;
    bb.exp_in   = '0;
    bb.mask_in  = '0;
`endif
    tick();
    tick();

    // Reset values
    chk("rst_se_a",   0, 32'(ba.se),       0);
    chk("rst_si_a",   0, 32'(ba.si),       0);
    chk("rst_busy_a", 0, 32'(ba.busy),     0);
    chk("rst_done_a", 0, 32'(ba.done),     0);
    chk("rst_resp_a", 0, 32'(ba.resp_out), 0);
    chk("rst_se_b",   0, 32'(bb.se),       0);
    chk("rst_resp_b", 0, 32'(bb.resp_out), 0);
`ifdef SCAN_CMP_EN
    chk("rst_fail_a", 0, 32'(ba.fail),     0);
`endif
    clr_ = 1'b1;
    tick();

    // Basic sequence, CAP_CYCLES=1
    p         = 16'hA5C3;
    ba.pat_in = p;
    ba.start  = 1'b1;
    tick();
    ba.start  = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      if (c <= 33) begin
        chk("basic_se",   c, 32'(ba.se),   (c == 17) ? 0 : 1);
        chk("basic_busy", c, 32'(ba.busy), 1);
        chk("basic_done", c, 32'(ba.done), 0);
      end else begin
        chk("basic_done", c, 32'(ba.done),     1);
        chk("basic_busy", c, 32'(ba.busy),     0);
        chk("basic_se",   c, 32'(ba.se),       0);
        chk("basic_resp", c, 32'(ba.resp_out), 32'h5A3C);
      end
      if (c <= 16) chk("basic_si", c, 32'(ba.si), 32'(p[CL-c]));
      tick();
    end
    chk("basic_done_end", 35, 32'(ba.done),     0);
    chk("basic_resp_hold", 35, 32'(ba.resp_out), 32'h5A3C);

    // Capture length, CAP_CYCLES=3
    bb.pat_in = 16'h0001;
    bb.start  = 1'b1;
    tick();
    bb.start  = 1'b0;
    low = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c <= 35) begin
        if (bb.se == 1'b0) low++;
        chk("cap_se",   c, 32'(bb.se),   (c >= 17 && c <= 19) ? 0 : 1);
        chk("cap_done", c, 32'(bb.done), 0);
      end else begin
        chk("cap_done", c, 32'(bb.done),     1);
        chk("cap_resp", c, 32'(bb.resp_out), 32'hFFFE);
      end
      tick();
    end
    chk("cap_se_low_count", 36, low, 3);

    // Reset mid-operation at cycle 20
    ba.pat_in = 16'hA5C3;
    ba.start  = 1'b1;
    tick();
    ba.start  = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    chk("midrst_pre_se",   20, 32'(ba.se),   1);
    chk("midrst_pre_busy", 20, 32'(ba.busy), 1);
    clr_ = 1'b0;
    #1;
    chk("midrst_se",   20, 32'(ba.se),       0);
    chk("midrst_si",   20, 32'(ba.si),       0);
    chk("midrst_busy", 20, 32'(ba.busy),     0);
    chk("midrst_done", 20, 32'(ba.done),     0);
    chk("midrst_resp", 20, 32'(ba.resp_out), 0);
    tick();
    tick();
    clr_ = 1'b1;
    for (int c = 0; c < 40; c++) begin
      chk("midrst_no_done", c, 32'(ba.done), 0);
      chk("midrst_idle",    c, 32'(ba.busy), 0);
      tick();
    end
    ba.pat_in = 16'h3C96;
    ba.start  = 1'b1;
    tick();
    ba.start  = 1'b0;
    for (int c = 1; c < 34; c++) tick();
    chk("midrst_restart_done", 34, 32'(ba.done),     1);
    chk("midrst_restart_resp", 34, 32'(ba.resp_out), 32'hC369);
    tick();

    // Back-to-back with start held high
    ba.pat_in = 16'h1234;
    ba.start  = 1'b1;
    tick();
    for (int c = 1; c <= 68; c++) begin
      if (c == 5)  ba.pat_in = 16'h0F0F;
      if (c == 20) ba.pat_in = 16'hFFFF;
      if (c == 40) ba.start  = 1'b0;
      chk("b2b_done", c, 32'(ba.done), (c == 34 || c == 68) ? 1 : 0);
      if (c == 34) begin
        chk("b2b_resp1", c, 32'(ba.resp_out), 32'hEDCB);
        chk("b2b_busy_done", c, 32'(ba.busy), 0);
      end
      if (c == 35) chk("b2b_busy_restart", c, 32'(ba.busy), 1);
      if (c == 35) chk("b2b_se_restart",   c, 32'(ba.se),   1);
      if (c == 50) chk("b2b_resp_hold",    c, 32'(ba.resp_out), 32'hEDCB);
      if (c == 68) chk("b2b_resp2",        c, 32'(ba.resp_out), 32'h0000);
      tick();
    end
    chk("b2b_idle_busy", 69, 32'(ba.busy), 0);
    chk("b2b_idle_done", 69, 32'(ba.done), 0);

`ifdef SCAN_CMP_EN
    begin
      logic [CL-1:0] ex [3];
      logic [CL-1:0] mk [3];
      logic          ef [3];
      ex[0] = 16'h5A3C; mk[0] = 16'hFFFF; ef[0] = 1'b0;
      ex[1] = 16'h5A3D; mk[1] = 16'hFFFF; ef[1] = 1'b1;
      ex[2] = 16'h5A3D; mk[2] = 16'hFFFE; ef[2] = 1'b0;
      for (int t = 0; t < 3; t++) begin
        ba.pat_in  = 16'hA5C3;
        ba.exp_in  = ex[t];
        ba.mask_in = mk[t];
        ba.start   = 1'b1;
        tick();
        ba.start   = 1'b0;
        ba.exp_in  = ~ex[t];
        ba.mask_in = '0;
        for (int c = 1; c < 34; c++) tick();
        chk("cmp_done", t, 32'(ba.done), 1);
        chk("cmp_fail", t, 32'(ba.fail), 32'(ef[t]));
        tick();
        chk("cmp_fail_hold", t, 32'(ba.fail), 32'(ef[t]));
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
